// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
//   Top-level game-flow FSM for the Sokoban core. Sequences level load,
//   click arbitration, move/retract commits, level clear and game over.
//   Owns the stage index, the committed-move step counter and the undo-depth
//   counter. Drives the game-state register load enable and source select.
//
//   Optional feature: define MOVE_LIMIT_EN to enable the per-level move
//   budget (MAX_MOVES). Without it, FAIL is unreachable and fail is tied 0.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   restart         pulse: abandon the game, return to stage 0
//   click           single-cycle player click
//   area_hit        click landed in the game area
//   retry_hit       click landed on the retry button
//   retract_hit     click landed on the retract button
//   move_ok         datapath reports the clicked move is legal
//   box_map         current box occupancy
//   dest_map        destination cells of the current level
//   stage_idx       current level
//   state_en        game-state register load enable
//   sel             state source: 0 = level ROM, 1 = move result, 3 = history pop
//   stage_up        one-cycle pulse on level advance
//   win             all levels cleared
//   fail            move budget exhausted
//   step_count      committed moves this level
//   undo_avail      at least one retractable move exists
module game_flow_ctrl #(
  parameter int CELLS      = 64,
  parameter int NUM_STAGES = 4,
  parameter int UNDO_DEPTH = 8,
  parameter int STEP_W     = 10,
  parameter int MAX_MOVES  = 200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          restart,
  input  logic                          click,
  input  logic                          area_hit,
  input  logic                          retry_hit,
  input  logic                          retract_hit,
  input  logic                          move_ok,
  input  logic [CELLS-1:0]              box_map,
  input  logic [CELLS-1:0]              dest_map,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic                          state_en,
  output logic [1:0]                    sel,
  output logic                          stage_up,
  output logic                          win,
  output logic                          fail,
  output logic [STEP_W-1:0]             step_count,
  output logic                          undo_avail
);

  localparam int SIDX_W = $clog2(NUM_STAGES);
  localparam int UNDO_W = $clog2(UNDO_DEPTH + 1);

  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_INIT    = 4'd1,
    ST_WAIT    = 4'd2,
    ST_DECIDE  = 4'd3,
    ST_MOVE    = 4'd4,
    ST_RETRACT = 4'd5,
    ST_PAUSE   = 4'd6,
    ST_NEXT    = 4'd7,
    ST_OVER    = 4'd8,
    ST_FAIL    = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [SIDX_W-1:0]   stage_q, stage_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [UNDO_W-1:0]   undo_q, undo_d;
  logic                state_en_q, state_en_d;
  logic [1:0]          sel_q, sel_d;
  logic                stage_up_q, stage_up_d;
  logic                win_q, win_d;
  logic                fail_q, fail_d;
  logic                undo_avail_q, undo_avail_d;

  logic level_clear;
  logic last_stage;

  assign level_clear = (box_map == dest_map);
  assign last_stage  = (stage_q == SIDX_W'(NUM_STAGES - 1));

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    step_d  = step_q;
    undo_d  = undo_q;

    case (state_q)
      ST_RESET:   state_d = ST_INIT;
      ST_INIT:    state_d = ST_WAIT;
      ST_WAIT: begin
        // A level clear takes precedence over a click in the same cycle.
        if (level_clear)
          state_d = last_stage ? ST_OVER : ST_PAUSE;
`ifdef MOVE_LIMIT_EN
        else if (step_q == STEP_W'(MAX_MOVES))
          state_d = ST_FAIL;
`endif
        else if (click)
          state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (retry_hit)
          state_d = ST_INIT;
        else if (retract_hit)
          state_d = (undo_q != '0) ? ST_RETRACT : ST_WAIT;
        else if (area_hit && move_ok)
          state_d = ST_MOVE;
        else
          state_d = ST_WAIT;
      end
      ST_MOVE:    state_d = ST_WAIT;
      ST_RETRACT: state_d = ST_WAIT;
      ST_PAUSE:   if (click) state_d = ST_NEXT;
      ST_NEXT:    state_d = ST_INIT;
      ST_OVER:    state_d = ST_OVER;
`ifdef MOVE_LIMIT_EN
      ST_FAIL:    if (click) state_d = ST_INIT;
`endif
      default:    state_d = ST_RESET;
    endcase

    if (reset || restart)
      state_d = ST_RESET;

    // Counters change on entry to a state, so their value is already
    // updated during the cycle that state is held.
    case (state_d)
      ST_RESET: begin
        stage_d = '0;
        step_d  = '0;
        undo_d  = '0;
      end
      ST_INIT: begin
        step_d = '0;
        undo_d = '0;
      end
      ST_MOVE: begin
        if (step_q != '1)
          step_d = step_q + STEP_W'(1);
        // History ring overwrites its oldest entry once full.
        if (undo_q < UNDO_W'(UNDO_DEPTH))
          undo_d = undo_q + UNDO_W'(1);
      end
      ST_RETRACT: begin
        if (undo_q != '0)
          undo_d = undo_q - UNDO_W'(1);
        if (step_q != '0)
          step_d = step_q - STEP_W'(1);
      end
      ST_NEXT:  stage_d = stage_q + SIDX_W'(1);
      default:  ;
    endcase

    // Registered outputs follow the state being entered.
    state_en_d   = (state_d == ST_RESET) || (state_d == ST_INIT) ||
                   (state_d == ST_MOVE)  || (state_d == ST_RETRACT);
    sel_d        = (state_d == ST_MOVE)    ? 2'd1 :
                   (state_d == ST_RETRACT) ? 2'd3 : 2'd0;
    stage_up_d   = (state_d == ST_NEXT);
    win_d        = (state_d == ST_OVER);
`ifdef MOVE_LIMIT_EN
    fail_d       = (state_d == ST_FAIL);
`else
    fail_d       = 1'b0;
`endif
    undo_avail_d = (undo_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      stage_q      <= '0;
      step_q       <= '0;
      undo_q       <= '0;
      state_en_q   <= 1'b1;
      sel_q        <= 2'd0;
      stage_up_q   <= 1'b0;
      win_q        <= 1'b0;
      fail_q       <= 1'b0;
      undo_avail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      step_q       <= step_d;
      undo_q       <= undo_d;
      state_en_q   <= state_en_d;
      sel_q        <= sel_d;
      stage_up_q   <= stage_up_d;
      win_q        <= win_d;
      fail_q       <= fail_d;
      undo_avail_q <= undo_avail_d;
    end
  end

  assign stage_idx  = stage_q;
  assign step_count = step_q;
  assign state_en   = state_en_q;
  assign sel        = sel_q;
  assign stage_up   = stage_up_q;
  assign win        = win_q;
  assign fail       = fail_q;
  assign undo_avail = undo_avail_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl
//   Directed plus randomized stimulus for game_flow_ctrl (default build).
//   Expected values come from a transaction-level model of the game rules:
//   per-click outcome, step/undo arithmetic, and stage progression.
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        reset, restart, click, area_hit, retry_hit, retract_hit, move_ok;
  logic [63:0] box_map, dest_map;
  logic [1:0]  stage_idx;
  logic        state_en, stage_up, win, fail, undo_avail;
  logic [1:0]  sel;
  logic [9:0]  step_count;

  int vectors = 0;
  int errors  = 0;
  int txn_no  = 0;

  // Reference model state
  int m_stage = 0;
  int m_steps = 0;
  int m_undo  = 0;

  game_flow_ctrl dut (
    .clk(clk), .reset(reset), .restart(restart), .click(click),
    .area_hit(area_hit), .retry_hit(retry_hit), .retract_hit(retract_hit),
    .move_ok(move_ok), .box_map(box_map), .dest_map(dest_map),
    .stage_idx(stage_idx), .state_en(state_en), .sel(sel),
    .stage_up(stage_up), .win(win), .fail(fail),
    .step_count(step_count), .undo_avail(undo_avail)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Board with at least one box off its destination.
  task automatic idle_board();
    dest_map = {$urandom, $urandom};
    box_map  = dest_map ^ (64'h1 << $urandom_range(63, 0));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_stage"}, stage_idx, 0);
    chk({tag, "_steps"}, step_count, 0);
    chk({tag, "_undo"}, undo_avail, 0);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_stage_up"}, stage_up, 0);
    chk({tag, "_en"}, state_en, 1);
    chk({tag, "_sel"}, sel, 0);
  endtask

  // Leave RESET: one cycle of INIT (ROM load), then WAIT.
  task automatic leave_reset();
    reset = 1'b0;
    restart = 1'b0;
    tick();
    chk("init_en", state_en, 1);
    chk("init_sel", sel, 0);
    tick();
    chk("wait_en", state_en, 0);
    m_stage = 0; m_steps = 0; m_undo = 0;
  endtask

  // One click from WAIT; observes DECIDE, the commit cycle, and back in WAIT.
  task automatic click_txn(input bit a, input bit rt, input bit rr, input bit ok);
    logic       exp_en;
    logic [1:0] exp_sel;
    if (rt) begin
      m_steps = 0; m_undo = 0; exp_en = 1; exp_sel = 2'd0;
    end else if (rr) begin
      if (m_undo > 0) begin
        m_undo--;
        if (m_steps > 0) m_steps--;
        exp_en = 1; exp_sel = 2'd3;
      end else begin
        exp_en = 0; exp_sel = 2'd0;
      end
    end else if (a && ok) begin
      if (m_steps < 1023) m_steps++;
      if (m_undo < 8) m_undo++;
      exp_en = 1; exp_sel = 2'd1;
    end else begin
      exp_en = 0; exp_sel = 2'd0;
    end
    click = 1; area_hit = a; retry_hit = rt; retract_hit = rr; move_ok = ok;
    tick();
    click = 0;
    chk("decide_en", state_en, 0);
    tick();
    chk("commit_en", state_en, exp_en);
    chk("commit_sel", sel, exp_sel);
    area_hit = 0; retry_hit = 0; retract_hit = 0; move_ok = 0;
    tick();
    chk("after_en", state_en, 0);
    chk("after_steps", step_count, m_steps);
    chk("after_undo", undo_avail, (m_undo != 0));
    chk("after_stage", stage_idx, m_stage);
    txn_no++;
    $display("txn %0d: a=%0b rt=%0b rr=%0b ok=%0b -> en=%0b sel=%0d steps=%0d undo=%0d",
             txn_no, a, rt, rr, ok, exp_en, exp_sel, m_steps, m_undo);
  endtask

  // Clear the current (non-final) level and advance to the next one.
  task automatic clear_level();
    box_map = dest_map;
    tick();
    chk("pause_en", state_en, 0);
    chk("pause_stage_up", stage_up, 0);
    tick();
    chk("pause_hold_stage_up", stage_up, 0);
    click = 1;
    tick();
    click = 0;
    m_stage++; m_steps = 0; m_undo = 0;
    chk("next_stage_up", stage_up, 1);
    chk("next_stage_idx", stage_idx, m_stage);
    idle_board();
    tick();
    chk("load_stage_up", stage_up, 0);
    chk("load_en", state_en, 1);
    chk("load_sel", sel, 0);
    chk("load_steps", step_count, 0);
    tick();
    chk("load_wait_en", state_en, 0);
    $display("txn stage advance -> stage %0d", m_stage);
  endtask

  initial begin
    reset = 1; restart = 0; click = 0; area_hit = 0; retry_hit = 0;
    retract_hit = 0; move_ok = 0;
    idle_board();
    tick();
    tick();
    chk_reset_values("reset");
    leave_reset();

    // Level load and 3 moves
    for (int i = 0; i < 3; i++) click_txn(1, 0, 0, 1);
    chk("three_moves_steps", step_count, 3);
    chk("three_moves_undo", undo_avail, 1);

    // Undo saturation: 10 moves then 9 retracts
    click_txn(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) click_txn(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) click_txn(0, 0, 1, 0);
    chk("undo_empty_after_8", undo_avail, 0);
    click_txn(0, 0, 1, 0);
    chk("undo_sat_steps", step_count, 2);

    // Retry after 5 moves
    for (int i = 0; i < 5; i++) click_txn(1, 0, 0, 1);
    click_txn(0, 1, 0, 0);
    chk("retry_steps", step_count, 0);
    chk("retry_undo", undo_avail, 0);

    // Randomized clicks
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 99);
      click_txn($urandom_range(0, 1) == 1, r < 4, (r >= 4) && (r < 34),
                $urandom_range(0, 3) != 0);
    end

    // Level progression 0 -> 1 -> 2
    clear_level();
    for (int i = 0; i < 4; i++) click_txn(1, 0, 0, 1);
    clear_level();
    chk("stage2_idx", stage_idx, 2);

    // Reset in the MOVE cycle
    click = 1; area_hit = 1; move_ok = 1;
    tick();
    click = 0;
    tick();
    chk("mid_move_en", state_en, 1);
    chk("mid_move_sel", sel, 1);
    area_hit = 0; move_ok = 0;
    reset = 1;
    tick();
    chk_reset_values("mid_move_reset");
    leave_reset();

    // Progress to the final stage
    clear_level();
    clear_level();
    click_txn(1, 0, 0, 1);
    clear_level();
    chk("stage3_idx", stage_idx, 3);

    // Final clear with a simultaneous click
    box_map = dest_map;
    click = 1; area_hit = 1; move_ok = 1;
    tick();
    click = 0; area_hit = 0; move_ok = 0;
    chk("over_win", win, 1);
    chk("over_en", state_en, 0);
    for (int i = 0; i < 3; i++) begin
      click = 1; area_hit = 1; move_ok = 1;
      tick();
      click = 0; area_hit = 0; move_ok = 0;
      tick();
      chk("over_ignore_en", state_en, 0);
      chk("over_hold_win", win, 1);
      chk("over_steps", step_count, 0);
    end
    $display("txn final clear -> win");
    restart = 1;
    tick();
    chk_reset_values("restart");
    idle_board();
    leave_reset();
    click_txn(1, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
